// File: rtl/bram_burst_streamer.sv
// BRAM region reader presenting the words as an AXI4-Stream master.
// A 1-deep read pipeline plus a 2-entry FIFO absorbs back-pressure. When the
// FIFO is empty, the word arriving from the BRAM is shown on the stream
// directly. This gives TVALID two cycles after START, and every source of
// TVALID is a register.
module bram_burst_streamer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
    input  logic [ADDR_WIDTH:0]   WORD_COUNT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR,
    output logic                  BRAM_EN,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    input  logic [DATA_WIDTH-1:0] BRAM_DOUT,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [CNT_W-1:0]                reads_left_q, reads_left_d;
    logic [CNT_W-1:0]                words_left_q, words_left_d;
    logic [BEAT_W-1:0]               beat_q, beat_d;
    logic                            inflight_q, inflight_d;
    logic                            inflight_last_q, inflight_last_d;
    logic [1:0]                      fifo_cnt_q, fifo_cnt_d;
    logic [1:0][DATA_WIDTH-1:0]      fifo_data_q, fifo_data_d;
    logic [1:0]                      fifo_last_q, fifo_last_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            error_q, error_d;

    logic                            hs;
    logic                            issue;
    logic                            push;
    logic                            pop;
    logic                            word_last;
    logic [2:0]                      occ;

    // Stream head: oldest FIFO entry, else the word returning from the BRAM.
    assign M_AXIS_TVALID = inflight_q | (fifo_cnt_q != 2'd0);
    assign M_AXIS_TDATA  = (fifo_cnt_q != 2'd0) ? fifo_data_q[0] :
                           (inflight_q ? BRAM_DOUT : '0);
    assign M_AXIS_TLAST  = (fifo_cnt_q != 2'd0) ? fifo_last_q[0] :
                           (inflight_q & inflight_last_q);
    assign BRAM_EN       = issue;
    assign BRAM_ADDR     = addr_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERROR         = error_q;

    // Read issue, FIFO bookkeeping and FSM next state.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        reads_left_d    = reads_left_q;
        words_left_d    = words_left_q;
        beat_d          = beat_q;
        fifo_cnt_d      = fifo_cnt_q;
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        error_d         = error_q;

        hs        = M_AXIS_TVALID & M_AXIS_TREADY;
        occ       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
        issue     = (state_q == ST_RUN) && (reads_left_q != '0) &&
                    (occ < (3'd2 + {2'b00, hs}));
        word_last = (beat_q == BEAT_MAX) || (reads_left_q == CNT_W'(1));
        pop       = hs && (fifo_cnt_q != 2'd0);
        push      = inflight_q && !(hs && (fifo_cnt_q == 2'd0));

        inflight_d      = issue;
        inflight_last_d = issue & word_last;

        if (issue) begin
            addr_d       = addr_q + ADDR_WIDTH'(1);
            reads_left_d = reads_left_q - CNT_W'(1);
            beat_d       = (beat_q == BEAT_MAX) ? '0 : beat_q + BEAT_W'(1);
        end

        if (hs) begin
            words_left_d = words_left_q - CNT_W'(1);
        end

        // FIFO shifts toward entry 0; at most 2 words are ever outstanding.
        case ({pop, push})
            2'b10: begin
                fifo_data_d[0] = fifo_data_q[1];
                fifo_last_d[0] = fifo_last_q[1];
                fifo_cnt_d     = fifo_cnt_q - 2'd1;
            end
            2'b01: begin
                if (fifo_cnt_q == 2'd0) begin
                    fifo_data_d[0] = BRAM_DOUT;
                    fifo_last_d[0] = inflight_last_q;
                end else begin
                    fifo_data_d[1] = BRAM_DOUT;
                    fifo_last_d[1] = inflight_last_q;
                end
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    fifo_data_d[0] = BRAM_DOUT;
                    fifo_last_d[0] = inflight_last_q;
                end else begin
                    fifo_data_d[0] = fifo_data_q[1];
                    fifo_last_d[0] = fifo_last_q[1];
                    fifo_data_d[1] = BRAM_DOUT;
                    fifo_last_d[1] = inflight_last_q;
                end
            end
            default: ;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    error_d      = 1'b0;
                    addr_d       = BASE_ADDR;
                    reads_left_d = WORD_COUNT;
                    words_left_d = WORD_COUNT;
                    beat_d       = '0;
                    state_d      = (WORD_COUNT == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && (reads_left_q == CNT_W'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (hs && (words_left_q == CNT_W'(1))) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (START && (state_q != ST_IDLE)) begin
            error_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FIN);
    end

    // State and datapath registers; reset aborts any transfer at once.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            reads_left_q    <= '0;
            words_left_q    <= '0;
            beat_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_cnt_q      <= 2'd0;
            fifo_data_q     <= '0;
            fifo_last_q     <= 2'b00;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            reads_left_q    <= reads_left_d;
            words_left_q    <= words_left_d;
            beat_q          <= beat_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_cnt_q      <= fifo_cnt_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
        end
    end

endmodule

// File: tb/tb_bram_burst_streamer.sv
// Directed bench for bram_burst_streamer: BRAM model holding BRAM[i]=i,
// per-cycle monitor at the falling edge, beat-by-beat comparison.
module tb_bram_burst_streamer;

    logic        ACLK;
    logic        ARESETN;
    logic        START;
    logic [11:0] BASE_ADDR;
    logic [12:0] WORD_COUNT;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;
    logic        BRAM_EN;
    logic [11:0] BRAM_ADDR;
    logic [31:0] BRAM_DOUT;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TLAST;

    bram_burst_streamer #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .BURST_LEN  (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .START         (START),
        .BASE_ADDR     (BASE_ADDR),
        .WORD_COUNT    (WORD_COUNT),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERROR         (ERROR),
        .BRAM_EN       (BRAM_EN),
        .BRAM_ADDR     (BRAM_ADDR),
        .BRAM_DOUT     (BRAM_DOUT),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TLAST  (M_AXIS_TLAST)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Synchronous-read BRAM with 1-cycle latency.
    logic [31:0] mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
    end
    always @(posedge ACLK) begin
        if (BRAM_EN) BRAM_DOUT <= mem[BRAM_ADDR];
    end

    int          n_vec;
    int          n_err;
    int          cyc;
    int          n_issued;
    int          n_hs;
    int          n_done;
    int          n_busy;
    int          first_en;
    int          first_v;
    int          done_cyc;
    int          last_hs;
    logic [32:0] beats [$];
    logic [11:0] addr_log [$];
    logic        prev_v;
    logic        prev_r;
    logic [31:0] prev_d;
    logic        prev_l;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy_val(input bit rnd);
        return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic clear_logs();
        beats.delete();
        addr_log.delete();
        n_issued = 0;
        n_hs     = 0;
        n_done   = 0;
        n_busy   = 0;
        first_en = -1;
        first_v  = -1;
        done_cyc = -1;
        last_hs  = -1;
    endtask

    // One clock: drive inputs on the falling edge, then observe what the
    // DUT presents to the next rising edge.
    task automatic tick(input logic st, input logic rdy);
        @(negedge ACLK);
        START         = st;
        M_AXIS_TREADY = rdy;
        #1;
        cyc++;
        if (prev_v && !prev_r) begin
            check("hold_valid", 64'(M_AXIS_TVALID), 64'(1));
            check("hold_data", 64'(M_AXIS_TDATA), 64'(prev_d));
            check("hold_last", 64'(M_AXIS_TLAST), 64'(prev_l));
        end
        if (BRAM_EN) begin
            addr_log.push_back(BRAM_ADDR);
            n_issued++;
            if (first_en < 0) first_en = cyc;
        end
        if (M_AXIS_TVALID && first_v < 0) first_v = cyc;
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            beats.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
            n_hs++;
            last_hs = cyc;
        end
        if (BRAM_EN) check("read_ahead", 64'((n_issued - n_hs) <= 2), 64'(1));
        if (BUSY) n_busy++;
        if (DONE) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        prev_v = M_AXIS_TVALID;
        prev_r = M_AXIS_TREADY;
        prev_d = M_AXIS_TDATA;
        prev_l = M_AXIS_TLAST;
    endtask

    task automatic check_beats(input logic [11:0] base, input int cnt);
        check("beat_count", 64'(beats.size()), 64'(cnt));
        for (int i = 0; i < beats.size() && i < cnt; i++) begin
            logic [11:0] a;
            logic        l;
            a = base + 12'(i);
            l = ((i % 16) == 15) || (i == cnt - 1);
            check($sformatf("beat%0d_data", i), 64'(beats[i][31:0]), 64'({20'h0, a}));
            check($sformatf("beat%0d_last", i), 64'(beats[i][32]), 64'(l));
        end
    endtask

    // Full transfer; inj >= 0 pulses a stray START that many cycles in.
    task automatic run_xfer(input logic [11:0] base, input int cnt, input bit rnd, input int inj);
        int  st_cyc;
        bit  seen;
        clear_logs();
        BASE_ADDR  = base;
        WORD_COUNT = 13'(cnt);
        tick(1'b1, rdy_val(rnd));
        st_cyc = cyc;
        seen   = 1'b0;
        for (int i = 0; i < 4 * cnt + 100 && !seen; i++) begin
            if (i == inj) begin
                BASE_ADDR  = 12'h500;
                WORD_COUNT = 13'd3;
            end
            tick(i == inj, rdy_val(rnd));
            seen = (n_done != 0);
        end
        check("done_seen", 64'(seen), 64'(1));
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("done_once", 64'(n_done), 64'(1));
        check("busy_end", 64'(BUSY), 64'(0));
        check_beats(base, cnt);
        if (cnt > 0) begin
            check("done_after_last", 64'(done_cyc - last_hs), 64'(1));
            if (!rnd) begin
                check("lat_en", 64'(first_en - st_cyc), 64'(1));
                check("lat_valid", 64'(first_v - st_cyc), 64'(2));
                check("back_to_back", 64'(last_hs - first_v), 64'(cnt - 1));
            end
        end else begin
            check("zero_no_valid", 64'(first_v == -1), 64'(1));
            check("zero_done_lat", 64'(done_cyc - st_cyc), 64'(1));
            check("zero_busy_len", 64'(n_busy), 64'(1));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(BUSY), 64'(0));
        check({tag, "_done"}, 64'(DONE), 64'(0));
        check({tag, "_error"}, 64'(ERROR), 64'(0));
        check({tag, "_en"}, 64'(BRAM_EN), 64'(0));
        check({tag, "_addr"}, 64'(BRAM_ADDR), 64'(0));
        check({tag, "_valid"}, 64'(M_AXIS_TVALID), 64'(0));
        check({tag, "_data"}, 64'(M_AXIS_TDATA), 64'(0));
        check({tag, "_last"}, 64'(M_AXIS_TLAST), 64'(0));
    endtask

    initial begin
        int hs_at_rst;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_d = '0;
        prev_l = 1'b0;
        clear_logs();
        ARESETN       = 1'b0;
        START         = 1'b0;
        BASE_ADDR     = '0;
        WORD_COUNT    = '0;
        M_AXIS_TREADY = 1'b0;
        #2;
        check_all_zero("reset");
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Basic 40-word transfer, TREADY held high.
        run_xfer(12'h010, 40, 1'b0, -1);
        // Same transfer under random back-pressure.
        run_xfer(12'h010, 40, 1'b1, -1);

        // Address wrap at the top of the BRAM.
        run_xfer(12'hFFE, 4, 1'b0, -1);
        check("wrap_n", 64'(addr_log.size()), 64'(4));
        if (addr_log.size() == 4) begin
            check("wrap_a0", 64'(addr_log[0]), 64'(12'hFFE));
            check("wrap_a1", 64'(addr_log[1]), 64'(12'hFFF));
            check("wrap_a2", 64'(addr_log[2]), 64'(12'h000));
            check("wrap_a3", 64'(addr_log[3]), 64'(12'h001));
        end

        // Empty transfer.
        run_xfer(12'h123, 0, 1'b0, -1);
        check("zero_error", 64'(ERROR), 64'(0));

        // Stray START mid-transfer sets ERROR; next accepted START clears it.
        run_xfer(12'h010, 40, 1'b0, 10);
        check("err_set", 64'(ERROR), 64'(1));
        run_xfer(12'h100, 20, 1'b0, -1);
        check("err_clr", 64'(ERROR), 64'(0));

        // Reset after beat 5 of 40.
        clear_logs();
        BASE_ADDR  = 12'h010;
        WORD_COUNT = 13'd40;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 100 && n_hs < 6; i++) tick(1'b0, 1'b1);
        check("rst_pre_beats", 64'(n_hs), 64'(6));
        #1;
        ARESETN = 1'b0;
        #1;
        check_all_zero("midrst");
        prev_v = 1'b0;
        hs_at_rst = n_hs;
        repeat (3) tick(1'b0, 1'b1);
        ARESETN = 1'b1;
        repeat (6) tick(1'b0, 1'b1);
        check("rst_no_beats", 64'(n_hs), 64'(hs_at_rst));
        check("rst_idle", 64'(BUSY), 64'(0));
        run_xfer(12'h020, 8, 1'b0, -1);

        // Full-BRAM transfer wraps to BASE_ADDR-1.
        run_xfer(12'h123, 4096, 1'b0, -1);
        check("full_n", 64'(addr_log.size()), 64'(4096));
        if (addr_log.size() == 4096) begin
            check("full_last_addr", 64'(addr_log[4095]), 64'(12'h122));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram_burst_streamer.md
Name: bram_burst_streamer

Overview:
- Reads a contiguous word region from the capture BRAM and presents it as an AXI4-Stream master.
- TLAST is asserted on every BURST_LEN-th beat and on the final beat.
- Sits directly upstream of the BRAM-to-DDR burst writer, which consumes one stream packet per DDR burst.
- Sustains one beat per clock under continuous TREADY and tolerates arbitrary back-pressure despite the 1-cycle BRAM read latency.

Parameters:
ADDR_WIDTH, 12, BRAM word-address width
DATA_WIDTH, 32, BRAM and stream data width
BURST_LEN, 16, beats per stream packet (TLAST spacing); integer >= 1

Ports:
ACLK  in  1  system clock
ARESETN  in  1  asynchronous active-low reset
START  in  1  1-cycle pulse; sampled only in IDLE
BASE_ADDR  in  ADDR_WIDTH  first BRAM word address, latched on accepted START
WORD_COUNT  in  ADDR_WIDTH+1  words to transfer, latched on accepted START
BUSY  out  1  high from accepted START until DONE
DONE  out  1  1-cycle pulse when the last beat handshakes
ERROR  out  1  sticky; START seen while BUSY
BRAM_EN  out  1  BRAM read enable
BRAM_ADDR  out  ADDR_WIDTH  BRAM word address
BRAM_DOUT  in  DATA_WIDTH  BRAM read data, valid 1 cycle after BRAM_EN
M_AXIS_TDATA  out  DATA_WIDTH  stream data
M_AXIS_TVALID  out  1  stream valid
M_AXIS_TREADY  in  1  stream ready
M_AXIS_TLAST  out  1  end of packet

Behaviour:
- Reset (ARESETN low, asynchronous): all outputs 0; FSM to IDLE; internal buffer emptied; ERROR cleared.
- FSM states:
  - IDLE: START with WORD_COUNT>0 latches BASE_ADDR and WORD_COUNT and goes to RUN. START with WORD_COUNT=0 goes to FIN with no beats.
  - RUN: issues BRAM reads. Moves to DRAIN once WORD_COUNT reads have been issued.
  - DRAIN: waits for the buffer and in-flight read to empty through handshakes.
  - FIN: pulses DONE for 1 cycle, then returns to IDLE.
- BUSY: 1 in RUN, DRAIN and FIN; 0 in IDLE.
- Read issue rule:
  - BRAM_EN=1 in a cycle only if reads remain and (buffered words + in-flight reads) < 2, counting a word that handshakes this cycle as freed.
  - A 2-entry output FIFO/skid captures BRAM_DOUT one cycle after BRAM_EN.
  - No data is ever dropped or duplicated.
- Addressing: BRAM_ADDR starts at BASE_ADDR and increments by 1 per issued read. It wraps modulo 2^ADDR_WIDTH.
- Latency with TREADY held high: START accepted at cycle 0 → BRAM_EN=1 at cycle 1 → TVALID=1 at cycle 2 → one beat per cycle thereafter.
- Stream rules:
  - TVALID, TDATA and TLAST are held stable while TVALID=1 and TREADY=0.
  - TVALID never depends combinationally on TREADY.
- TLAST is driven by a beat counter that resets at each packet start. TLAST=1 when the beat index within the packet equals BURST_LEN-1, or when the beat is the final word of the transfer. A short final packet is allowed.
- DONE rises in the cycle after the final beat handshakes (TVALID&TREADY&TLAST of the last word).
- START while BUSY: ignored for transfer purposes; sets ERROR. ERROR stays high until the next accepted START in IDLE, which clears it.
- Reset mid-transfer: the transfer is aborted immediately. No beat is emitted after ARESETN deasserts until a new START.
- WORD_COUNT maximum 2^ADDR_WIDTH: the full BRAM is read once, wrapping back to BASE_ADDR-1.

Test Plan:
- BASE_ADDR=0x010, WORD_COUNT=40, BURST_LEN=16, BRAM[i]=i, TREADY=1 → 40 beats of TDATA 0x10..0x37 on consecutive cycles; TLAST at beats 15, 31 and 39; first TVALID 2 cycles after START; DONE 1 cycle after beat 39.
- Same transfer with TREADY random at 50% → identical data and TLAST sequence; TDATA held stable whenever TVALID=1 and TREADY=0; BRAM_EN issued at most 2 reads ahead.
- BASE_ADDR=0xFFE, WORD_COUNT=4, ADDR_WIDTH=12 → BRAM_ADDR sequence 0xFFE, 0xFFF, 0x000, 0x001; TLAST on beat 3 only.
- WORD_COUNT=0 → no TVALID; BUSY high for 1 cycle; DONE pulse 1 cycle after START; ERROR=0.
- Second START pulsed mid-transfer → ERROR=1 and transfer unaffected. The next START in IDLE clears ERROR and runs normally.
- ARESETN low for 3 cycles after beat 5 of 40 → all outputs 0 immediately; no further beats; a new START with WORD_COUNT=8 completes with 8 correct beats.
